// File: rtl/sdivrem.sv
// sdivrem: iterative restoring signed divider with valid/ready handshake, truncated quotient and remainder
module sdivrem #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_by_zero,
  output logic              overflow
);
  localparam int CW = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0] MIN = {1'b1, {(DWIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt;
  logic [DWIDTH-1:0] pr, dq, dv, pr_n, dq_n, q_s, r_s;
  logic [DWIDTH:0] diff;
  logic sign_q, sign_r, dz, ov, last, accept;
  always_ff @(posedge clk)
    if (aclr) st <= IDLE;
    else if (ena) st <= st_n;
  // With a zero divisor every trial subtract succeeds, so the partial remainder ends
  // as |dividend| and the signed remainder reproduces the dividend as presented.
  always_comb begin
    last = cnt == CW'(DWIDTH-1);
    accept = st == IDLE && in_valid;
    st_n = accept ? CALC : (st == CALC && last) ? DONE : (st == DONE && out_ready) ? IDLE : st;
    in_ready = st == IDLE;
    out_valid = st == DONE;
    diff = {pr, dq[DWIDTH-1]} - {1'b0, dv};
    pr_n = diff[DWIDTH] ? {pr[DWIDTH-2:0], dq[DWIDTH-1]} : diff[DWIDTH-1:0];
    dq_n = {dq[DWIDTH-2:0], ~diff[DWIDTH]};
    q_s = dz ? '1 : ov ? MIN : sign_q ? -dq_n : dq_n;
    r_s = ov ? '0 : sign_r ? -pr_n : pr_n;
  end
  always_ff @(posedge clk)
    if (aclr) begin
      cnt <= '0;
      pr <= '0;
      dq <= '0;
      dv <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        cnt <= '0;
        pr <= '0;
        dq <= dividend[DWIDTH-1] ? -dividend : dividend;
        dv <= divisor[DWIDTH-1] ? -divisor : divisor;
        sign_q <= dividend[DWIDTH-1] ^ divisor[DWIDTH-1];
        sign_r <= dividend[DWIDTH-1];
        dz <= divisor == '0;
        ov <= dividend == MIN && divisor == '1;
      end else if (st == CALC) begin
        cnt <= cnt + 1'b1;
        pr <= pr_n;
        dq <= dq_n;
        if (last) begin
          quotient <= q_s;
          remainder <= r_s;
          div_by_zero <= dz;
          overflow <= ov;
        end
      end
    end
endmodule

// File: tb/tb_sdivrem.sv
// tb_sdivrem: scoreboard bench for sdivrem; a reference model predicts every result at accept time
module tb_sdivrem;
  localparam int DW = 16;
  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic dz;
    logic ov;
  } res_t;
  logic clk = 1'b0;
  logic aclr = 1'b1, ena = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [DW-1:0] dividend = '0, divisor = '0, quotient, remainder;
  res_t sb[$];
  res_t mon_e, mon_g;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sdivrem #(.DWIDTH(DW)) dut (
    .clk(clk), .aclr(aclr), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );
  function automatic res_t model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    res_t e;
    longint la, lb;
    la = a;
    lb = b;
    e = '0;
    if (lb == 0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
    end else if (la == -(longint'(1) << (DW-1)) && lb == -1) begin
      e.q = {1'b1, {(DW-1){1'b0}}};
      e.ov = 1'b1;
    end else begin
      e.q = DW'(la / lb);
      e.r = DW'(la % lb);
    end
    return e;
  endfunction
  function automatic logic [DW-1:0] rv();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return DW'(1);
      2: return '1;
      3: return {1'b1, {(DW-1){1'b0}}};
      4: return {1'b0, {(DW-1){1'b1}}};
      5: return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction
  always @(negedge clk)
    if (!aclr && ena && out_valid && out_ready) begin
      mon_g = '{q: quotient, r: remainder, dz: div_by_zero, ov: overflow};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got q=%0d r=%0d dz=%b ov=%b with nothing expected",
                 $signed(quotient), $signed(remainder), div_by_zero, overflow);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL result got q=%0d r=%0d dz=%b ov=%b expected q=%0d r=%0d dz=%b ov=%b",
                   $signed(mon_g.q), $signed(mon_g.r), mon_g.dz, mon_g.ov,
                   $signed(mon_e.q), $signed(mon_e.r), mon_e.dz, mon_e.ov);
        end
      end
    end
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    while (!(in_ready && ena)) begin
      if (n++ == 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout in_ready=%b expected 1 within 100 cycles", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor = DW'($urandom);
    sb.push_back(model(a, b));
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    aclr = 1'b1;
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    if (quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_data q=%h r=%h expected 0 0", quotient, remainder);
    end
    if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags dz=%b ov=%b expected 0 0", div_by_zero, overflow);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    int n = 1;
    send(DW'(100), DW'(7));
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != DW + 1) begin
      errors++;
      $display("FAIL latency edges=%0d expected %0d", n, DW + 1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one_cycle_valid out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    drain();
  endtask
  task automatic test_signs();
    int a[4] = '{-100, 100, -100, 6};
    int b[4] = '{7, -7, -7, -3};
    for (int i = 0; i < 4; i++) begin
      send(DW'(a[i]), DW'(b[i]));
      drain();
    end
  endtask
  task automatic test_specials();
    int a[5] = '{5, -32768, -32768, 32767, 0};
    int b[5] = '{0, -1, 1, -32768, 0};
    for (int i = 0; i < 5; i++) begin
      send(DW'(a[i]), DW'(b[i]));
      drain();
    end
  endtask
  task automatic test_backpressure();
    int n = 0;
    res_t e;
    e = model(DW'(50), DW'(6));
    out_ready = 1'b0;
    send(DW'(50), DW'(6));
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = DW'(9);
    divisor = DW'(2);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (quotient !== e.q || remainder !== e.r || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold q=%0d r=%0d out_valid=%b in_ready=%b expected %0d %0d 1 0",
                 $signed(quotient), $signed(remainder), out_valid, in_ready, $signed(e.q), $signed(e.r));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(DW'(9), DW'(2));
    drain();
  endtask
  task automatic test_stall();
    int n = 8;
    send(DW'(1234), DW'(-17));
    repeat (4) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != DW + 4) begin
      errors++;
      $display("FAIL stall_latency edges=%0d expected %0d", n, DW + 4);
    end
    drain();
  endtask
  task automatic test_reset_mid();
    send(DW'(300), DW'(7));
    sb.delete();
    repeat (7) @(posedge clk);
    #1;
    aclr = 1'b1;
    @(posedge clk);
    #1;
    aclr = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {2'b10, {(2*DW+2){1'b0}}}) begin
      errors++;
      $display("FAIL mid_reset in_ready=%b out_valid=%b q=%h r=%h dz=%b ov=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    repeat (40) @(posedge clk);
    #1;
    send(DW'(1000), DW'(-10));
    drain();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 2000; i++) send(rv(), rv());
    drain();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_specials();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
